frogger_life_ctrl: RTL and testbench
====================================

// Module: frogger_life_ctrl
//
// PURPOSE
//   Game-session controller sitting beside frogger_game: consumes the registered
//   frog/car collision flag and the start button, and tracks lives.
//   Drives the three lives LEDs, a game-active enable and a one-cycle frog
//   respawn request into frogger_ctrl.
//   Provides a post-hit invulnerability window measured in video frames, so one
//   overlap costs exactly one life.
//
// PARAMETERS
//   NUM_LIVES   3    lives loaded at game start (1..7)
//   HIT_FRAMES  60   frame ticks of invulnerability after a hit (>=1)
//   OVER_FRAMES 120  frame ticks after game over before start is accepted (>=1)
//
// PORTS
//   i_Clk          in   1  system clock (sole clock domain)
//   i_Reset        in   1  synchronous, active-high reset
//   i_Game_Start   in   1  start button, already debounced, level
//   i_Collided     in   1  frog overlaps a car, level, synchronous to i_Clk
//   i_Frame_Tick   in   1  one-cycle pulse per video frame (VSync start)
//   o_Game_Active  out  1  high in PLAYING and HIT; gates frog movement
//   o_Frog_Respawn out  1  one-cycle pulse: return frog to start tile
//   o_Game_Over    out  1  high in GAME_OVER
//   o_LED_2        out  1  high when lives >= 1
//   o_LED_3        out  1  high when lives >= 2
//   o_LED_4        out  1  high when lives >= 3
//   o_State        out  2  current state encoding (debug)
//
// BEHAVIOUR
//   Clock, reset and registers
//   - One clock, i_Clk. Reset is synchronous and active-high on i_Reset.
//   - All outputs are registered.
//   - Reset values: state=IDLE, lives=NUM_LIVES, frame counter=0,
//     o_Game_Active=0, o_Frog_Respawn=0, o_Game_Over=0,
//     LEDs reflect NUM_LIVES, edge-detector history=0.
//   - Reset asserted mid-game returns to IDLE the next edge; no respawn pulse.
//
//   Edge detection
//   - Rising edges of i_Game_Start and i_Collided are detected with 1-cycle
//     history registers. History runs in every state.
//   - A collision held high across states never produces a second hit; a new
//     hit needs a 0->1 transition.
//
//   States (IDLE=0, PLAYING=1, HIT=2, GAME_OVER=3)
//   - IDLE: lives=NUM_LIVES.
//     Start edge -> PLAYING; o_Frog_Respawn=1 for that one cycle.
//   - PLAYING: collision edge -> lives decremented.
//     If the prior lives value was 1 -> GAME_OVER, lives=0.
//     Otherwise -> HIT, counter=0, o_Frog_Respawn pulses.
//     Start edges are ignored.
//   - HIT: collisions are ignored. Each i_Frame_Tick increments the counter.
//     On the tick that makes counter==HIT_FRAMES -> PLAYING, counter cleared.
//   - GAME_OVER: frame ticks count up to OVER_FRAMES and saturate there.
//     A start edge with counter==OVER_FRAMES -> PLAYING: lives reloaded,
//     counter cleared, o_Frog_Respawn pulses.
//     A start edge before that is discarded; the button must be released
//     and pressed again.
//
//   Simultaneous events and widths
//   - Collision edge and frame tick in the same cycle in PLAYING: the hit
//     wins and the tick is not counted.
//   - Start edge and collision edge in the same cycle in IDLE: start wins,
//     and the collision is ignored.
//   - lives width = $clog2(NUM_LIVES+1). Counter width =
//     $clog2(max(HIT_FRAMES,OVER_FRAMES)+1). Neither may wrap: the
//     decrement only occurs from lives>=1, and the counter saturates.
//   - Latency: from a collision rising edge to the lives/LED update and the
//     respawn pulse is one cycle (registered on the next i_Clk edge).
//
// STRUCTURE
//   - frogger_pkg holds the state encoding localparams
//     (ST_IDLE, ST_PLAYING, ST_HIT, ST_GAME_OVER) and the shared game
//     constants (grid width/height, tile size).
//   - Sub-module rise_detect (clk, reset, in -> 1-cycle pulse) is instantiated
//     twice: once for start and once for collision.
//   - The FSM, lives counter and frame counter stay in this module.
//
// TESTING
//   - Reset, then pulse start -> o_State=1, o_Game_Active=1, one respawn
//     pulse, LEDs 2/3/4 = 1/1/1.
//   - In PLAYING, raise i_Collided for 10 cycles -> exactly one decrement,
//     LED_4=0, o_State=2.
//     Then 60 frame ticks -> o_State=1 on the 60th tick.
//   - Collision edges during HIT after 5 ticks -> lives unchanged (2) and
//     the counter continues.
//   - Three separated hits -> o_Game_Over=1, all LEDs 0, o_State=3.
//     Start at tick 50 -> ignored.
//     Start after tick 120 -> PLAYING with lives=3.
//   - i_Collided held high from HIT through return to PLAYING -> no hit
//     until it drops and rises again.
//   - Assert i_Reset during HIT -> IDLE next cycle, lives=3,
//     o_Frog_Respawn stays 0.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger game-session logic.
//   state_e  : life-controller state encoding (also visible on o_State)
//   GRID_*   : playfield size in tiles, TILE_SIZE in pixels
//   max_int  : helper for sizing counters from parameters
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_HIT       = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    localparam int GRID_W    = 16;
    localparam int GRID_H    = 12;
    localparam int TILE_SIZE = 40;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frogger_life_ctrl_if.sv
// Signal bundle between the game logic and the life controller.
//   i_Game_Start   debounced start button level
//   i_Collided     frog/car overlap level
//   i_Frame_Tick   one pulse per video frame
//   o_Game_Active  high while PLAYING or HIT
//   o_Frog_Respawn one-cycle request to put the frog back on the start tile
//   o_Game_Over    high in GAME_OVER
//   o_LED_2/3/4    lives >= 1 / >= 2 / >= 3
//   o_State        current state (debug)
interface frogger_life_ctrl_if;

    logic       i_Game_Start;
    logic       i_Collided;
    logic       i_Frame_Tick;
    logic       o_Game_Active;
    logic       o_Frog_Respawn;
    logic       o_Game_Over;
    logic       o_LED_2;
    logic       o_LED_3;
    logic       o_LED_4;
    logic [1:0] o_State;

    // master: game side driving events in; slave: the life controller
    modport master (
        output i_Game_Start, i_Collided, i_Frame_Tick,
        input  o_Game_Active, o_Frog_Respawn, o_Game_Over,
        input  o_LED_2, o_LED_3, o_LED_4, o_State
    );

    modport slave (
        input  i_Game_Start, i_Collided, i_Frame_Tick,
        output o_Game_Active, o_Frog_Respawn, o_Game_Over,
        output o_LED_2, o_LED_3, o_LED_4, o_State
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector with a one-cycle history register.
//   clk, reset : clock and synchronous active-high reset
//   in_i       : level input
//   pulse_o    : high for the cycle in which in_i is 1 and was 0 last cycle
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic pulse_o
);

    logic hist_q;

    always_ff @(posedge clk) begin
        if (reset) hist_q <= 1'b0;
        else       hist_q <= in_i;
    end

    assign pulse_o = in_i & ~hist_q;

endmodule

// File: rtl/frogger_life_ctrl.sv
// Game-session controller: tracks lives, gates play, requests frog respawns
// and enforces frame-counted invulnerability / game-over lockout windows.
//   i_Clk, i_Reset : clock, synchronous active-high reset
//   bus            : game-side event inputs and registered status outputs
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start, lives held at NUM_LIVES
// PLAYING    | frog live; a collision edge costs one life
// HIT        | invulnerable for HIT_FRAMES frame ticks
// GAME_OVER  | lives=0; start accepted once OVER_FRAMES ticks have elapsed
module frogger_life_ctrl
    import frogger_pkg::*;
#(
    parameter int NUM_LIVES   = 3,
    parameter int HIT_FRAMES  = 60,
    parameter int OVER_FRAMES = 120
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    frogger_life_ctrl_if.slave  bus
);

    localparam int LW = $clog2(NUM_LIVES + 1);
    localparam int CW = $clog2(max_int(HIT_FRAMES, OVER_FRAMES) + 1);

    localparam logic [LW-1:0] LIVES_INIT = LW'(NUM_LIVES);
    localparam logic [CW-1:0] HIT_LAST   = CW'(HIT_FRAMES - 1);
    localparam logic [CW-1:0] OVER_SAT   = CW'(OVER_FRAMES);

    state_e          state_q, state_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            respawn_q, respawn_d;
    logic            active_q, over_q;
    logic [2:0]      led_q, led_d;
    logic            start_rise, coll_rise;

    rise_detect u_start_rise (
        .clk     (i_Clk),
        .reset   (i_Reset),
        .in_i    (bus.i_Game_Start),
        .pulse_o (start_rise)
    );

    rise_detect u_coll_rise (
        .clk     (i_Clk),
        .reset   (i_Reset),
        .in_i    (bus.i_Collided),
        .pulse_o (coll_rise)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                lives_d = LIVES_INIT;
                cnt_d   = '0;
                if (start_rise) begin
                    state_d   = ST_PLAYING;
                    respawn_d = 1'b1;
                end
            end
            ST_PLAYING: begin
                // A hit takes priority over any frame tick in the same cycle;
                // ticks are not counted while playing anyway.
                if (coll_rise) begin
                    cnt_d = '0;
                    if (lives_q <= LW'(1)) begin
                        state_d = ST_GAME_OVER;
                        lives_d = '0;
                    end else begin
                        state_d   = ST_HIT;
                        lives_d   = lives_q - LW'(1);
                        respawn_d = 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (bus.i_Frame_Tick) begin
                    if (cnt_q == HIT_LAST) begin
                        state_d = ST_PLAYING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                // An early start edge is simply dropped; because the edge
                // detector has already consumed it, a fresh press is needed.
                if (start_rise && cnt_q == OVER_SAT) begin
                    state_d   = ST_PLAYING;
                    lives_d   = LIVES_INIT;
                    cnt_d     = '0;
                    respawn_d = 1'b1;
                end else if (bus.i_Frame_Tick && cnt_q != OVER_SAT) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        led_d = {int'(lives_d) >= 3, int'(lives_d) >= 2, int'(lives_d) >= 1};
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            cnt_q     <= '0;
            respawn_q <= 1'b0;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
            led_q     <= {NUM_LIVES >= 3, NUM_LIVES >= 2, NUM_LIVES >= 1};
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            respawn_q <= respawn_d;
            active_q  <= (state_d == ST_PLAYING) || (state_d == ST_HIT);
            over_q    <= (state_d == ST_GAME_OVER);
            led_q     <= led_d;
        end
    end

    assign bus.o_State        = state_q;
    assign bus.o_Game_Active  = active_q;
    assign bus.o_Game_Over    = over_q;
    assign bus.o_Frog_Respawn = respawn_q;
    assign bus.o_LED_2        = led_q[0];
    assign bus.o_LED_3        = led_q[1];
    assign bus.o_LED_4        = led_q[2];

endmodule

// File: tb/tb_frogger_life_ctrl.sv
// Bench for frogger_life_ctrl: scripted game scenarios followed by random
// play, every cycle compared against a rule-level model of the game session.
module tb_frogger_life_ctrl;

    localparam int N_LIVES = 3;
    localparam int HIT_F   = 60;
    localparam int OVER_F  = 120;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frogger_life_ctrl_if bus ();

    frogger_life_ctrl #(
        .NUM_LIVES   (N_LIVES),
        .HIT_FRAMES  (HIT_F),
        .OVER_FRAMES (OVER_F)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 playing, 2 hit, 3 game over
    int m_state  = 0;
    int m_lives  = N_LIVES;
    int m_frames = 0;
    int m_resp   = 0;
    bit m_prev_st = 0;
    bit m_prev_co = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit st, input bit co, input bit tk);
        bit start_edge, coll_edge;
        start_edge = st && !m_prev_st;
        coll_edge  = co && !m_prev_co;
        m_prev_st  = st;
        m_prev_co  = co;
        m_resp     = 0;
        if (r) begin
            m_state = 0; m_lives = N_LIVES; m_frames = 0;
            m_prev_st = 0; m_prev_co = 0;
            return;
        end
        case (m_state)
            0: if (start_edge) begin m_state = 1; m_resp = 1; end
            1: if (coll_edge) begin
                   m_frames = 0;
                   if (m_lives == 1) begin m_lives = 0; m_state = 3; end
                   else begin m_lives--; m_state = 2; m_resp = 1; end
               end
            2: if (tk) begin
                   m_frames++;
                   if (m_frames == HIT_F) begin m_state = 1; m_frames = 0; end
               end
            default: begin
                if (start_edge && m_frames == OVER_F) begin
                    m_state = 1; m_lives = N_LIVES; m_frames = 0; m_resp = 1;
                end else if (tk && m_frames < OVER_F) begin
                    m_frames++;
                end
            end
        endcase
    endtask

    function automatic int leds_now();
        return {29'd0, bus.o_LED_4, bus.o_LED_3, bus.o_LED_2};
    endfunction

    // Drive one cycle of inputs, let the DUT clock them, compare at negedge.
    task automatic step(input bit r, input bit st, input bit co, input bit tk);
        int exp_leds;
        rst              = r;
        bus.i_Game_Start = st;
        bus.i_Collided   = co;
        bus.i_Frame_Tick = tk;
        model(r, st, co, tk);
        @(negedge clk);
        exp_leds = ((m_lives >= 3) ? 4 : 0) + ((m_lives >= 2) ? 2 : 0) + ((m_lives >= 1) ? 1 : 0);
        chk("state",   int'(bus.o_State), m_state);
        chk("leds",    leds_now(), exp_leds);
        chk("respawn", int'(bus.o_Frog_Respawn), m_resp);
        chk("active",  int'(bus.o_Game_Active), (m_state == 1 || m_state == 2) ? 1 : 0);
        chk("over",    int'(bus.o_Game_Over), (m_state == 3) ? 1 : 0);
    endtask

    initial begin
        bit st, co;

        // reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_state", int'(bus.o_State), 0);
        chk("rst_leds",  leds_now(), 7);
        chk("rst_resp",  int'(bus.o_Frog_Respawn), 0);

        // start, with a simultaneous collision edge that must be ignored
        step(0, 1, 1, 0);
        chk("start_state",  int'(bus.o_State), 1);
        chk("start_active", int'(bus.o_Game_Active), 1);
        chk("start_resp",   int'(bus.o_Frog_Respawn), 1);
        chk("start_leds",   leds_now(), 7);
        step(0, 0, 0, 0);
        chk("start_resp_end", int'(bus.o_Frog_Respawn), 0);

        // collision held 10 cycles, tick on the hit cycle: one life lost
        step(0, 0, 1, 1);
        chk("hit_resp", int'(bus.o_Frog_Respawn), 1);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        chk("hit_leds",  leds_now(), 3);
        chk("hit_state", int'(bus.o_State), 2);
        step(0, 0, 0, 0);

        // 5 ticks, then collision edges that must be ignored during HIT
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        chk("hit_ignore_leds", leds_now(), 3);
        for (int i = 0; i < 55; i++) begin
            step(0, 0, 0, 1);
            if (i == 53) chk("hit_tick59", int'(bus.o_State), 2);
        end
        chk("hit_tick60", int'(bus.o_State), 1);

        // second hit, collision held across the return to PLAYING
        step(0, 0, 1, 0);
        chk("hit2_leds", leds_now(), 1);
        for (int i = 0; i < HIT_F; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        chk("held_no_hit", int'(bus.o_State), 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("go_state", int'(bus.o_State), 3);
        chk("go_leds",  leds_now(), 0);
        chk("go_over",  int'(bus.o_Game_Over), 1);
        step(0, 0, 0, 0);

        // early start is discarded, later start accepted
        for (int i = 0; i < 50; i++) step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        chk("go_early_start", int'(bus.o_State), 3);
        for (int i = 0; i < 80; i++) step(0, 1, 0, 1);
        chk("go_held_start", int'(bus.o_State), 3);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("restart_state", int'(bus.o_State), 1);
        chk("restart_leds",  leds_now(), 7);
        chk("restart_resp",  int'(bus.o_Frog_Respawn), 1);
        step(0, 0, 0, 0);

        // reset during HIT
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("rst_hit_state", int'(bus.o_State), 0);
        chk("rst_hit_leds",  leds_now(), 7);
        chk("rst_hit_resp",  int'(bus.o_Frog_Respawn), 0);
        step(0, 0, 0, 0);
        chk("rst_hit_resp2", int'(bus.o_Frog_Respawn), 0);

        // random play
        st = 0; co = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 24) == 0) st = ~st;
            if ($urandom_range(0, 11) == 0) co = ~co;
            step($urandom_range(0, 2999) == 0, st, co, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
